// File: rtl/distance_resolver_pkg.sv
// ---------------------------------------------------------------------------
// distance_resolver_pkg
//   Shared definitions for the distance resolver: FSM state encoding and the
//   fixed step counts of the two divisions that make up one request.
//   DIV_IDX_CYCLES : quotient bits produced for idx1/FW (one per cycle)
//   DIV_T_CYCLES   : quotient bits produced for t/OW   (one per cycle)
//   LATENCY        : cycles from the acceptance cycle (counted as cycle 0)
//                    to the first cycle with out_valid high
// ---------------------------------------------------------------------------
package distance_resolver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DIV_IDX = 3'd1,
    ST_DIV_T   = 3'd2,
    ST_CALC    = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam int DIV_IDX_CYCLES = 8;
  localparam int DIV_T_CYCLES   = 16;
  localparam int LATENCY        = DIV_IDX_CYCLES + DIV_T_CYCLES + 2;

  // Width of the divider step counter; must hold DIV_T_CYCLES.
  localparam int CNT_W = 5;

endpackage

// File: rtl/distance_resolver_seq_divider.sv
// ---------------------------------------------------------------------------
// distance_resolver_seq_divider
//   Restoring bit-serial divider, one quotient bit per cycle, MSB first.
//   The dividend is taken MSB-aligned in lop_i: for an N-bit division place
//   the operand in the top N bits and request nbits_i = N steps. The first
//   step is performed in the start cycle, so a division of N bits raises
//   done_o (one-cycle pulse) in the cycle after the N-th clock edge.
//   Divisor 0 naturally yields an all-ones quotient and rem = dividend.
// Ports
//   clk, reset      clock, asynchronous active-high reset
//   start_i         load operands and perform the first step (ignored nowhere;
//                   the caller only pulses it while the divider is idle)
//   nbits_i         number of quotient bits to produce (>= 2)
//   lop_i, dvs_i    dividend (MSB-aligned) and divisor
//   busy_o          steps still outstanding
//   done_o          one-cycle pulse: quot_o/rem_o are final
//   quot_o, rem_o   quotient (zero-extended) and remainder; held until next start
// ---------------------------------------------------------------------------
module distance_resolver_seq_divider #(
  parameter int W  = 16,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_i,
  input  logic [CW-1:0] nbits_i,
  input  logic [W-1:0]  lop_i,
  input  logic [W-1:0]  dvs_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [W-1:0]  quot_o,
  output logic [W-1:0]  rem_o
);

  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  quot_q, quot_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Operands of the step performed this cycle: fresh ones on start.
  logic [W-1:0] rem_src, quot_src, dvs_src;
  logic [W:0]   shifted;
  logic [W-1:0] rem_step, quot_step;

  always_comb begin
    rem_src  = start_i ? '0    : rem_q;
    quot_src = start_i ? lop_i : quot_q;
    dvs_src  = start_i ? dvs_i : dvs_q;

    // Bring the next dividend bit into the partial remainder; the quotient
    // register doubles as the dividend shift register.
    shifted   = {rem_src, quot_src[W-1]};
    quot_step = {quot_src[W-2:0], 1'b0};
    rem_step  = shifted[W-1:0];
    if (shifted >= {1'b0, dvs_src}) begin
      rem_step     = W'(shifted - {1'b0, dvs_src});
      quot_step[0] = 1'b1;
    end
  end

  always_comb begin
    rem_d  = rem_q;
    quot_d = quot_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start_i) begin
      rem_d  = rem_step;
      quot_d = quot_step;
      dvs_d  = dvs_i;
      cnt_d  = nbits_i - CW'(1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d  = rem_step;
      quot_d = quot_step;
      cnt_d  = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q  <= '0;
      quot_q <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign quot_o = quot_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/distance_resolver.sv
// ---------------------------------------------------------------------------
// distance_resolver
//   Rebuilds the larger index idx2 of a redundant weight pair from the smaller
//   index idx1 and the stride-scaled row distance dr:
//     r1 = idx1/FW, c1 = idx1%FW, t = dr*S + c1, dv = t/OW, c2 = t%OW,
//     r2 = r1 + dv, idx2 = r2*FW + c2,
//     hit = dr!=0 & c2<FW & r2<FH & idx2 fits in WORD_WIDTH bits.
//   One shared serial divider handles both divisions in turn.
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   in_valid / in_ready   request handshake (ready only while idle)
//   idx1, dr              pair index and encoded distance
//   ow, fw, fh, st        output width, filter width/height, stride
//   out_valid / out_ready result handshake; result held until consumed
//   idx2, hit             result (idx2 = 0 whenever hit = 0)
//   err                   only with DIST_RESOLVER_DIVZERO_EN: latched FW, OW
//                         or S was zero; forces hit = 0, idx2 = 0
// Configuration macro: DIST_RESOLVER_DIVZERO_EN
// ---------------------------------------------------------------------------
module distance_resolver
  import distance_resolver_pkg::*;
#(
  parameter int WORD_WIDTH = 8,
  parameter int DIST_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] idx1,
  input  logic [DIST_WIDTH-1:0] dr,
  input  logic [WORD_WIDTH-1:0] ow,
  input  logic [WORD_WIDTH-1:0] fw,
  input  logic [WORD_WIDTH-1:0] fh,
  input  logic [WORD_WIDTH-1:0] st,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] idx2,
  output logic                  hit
`ifdef DIST_RESOLVER_DIVZERO_EN
  ,
  output logic                  err
`endif
);

  localparam int W  = WORD_WIDTH;
  localparam int DW = 2 * WORD_WIDTH;  // divider width, holds t
  localparam int PW = DW + W + 2;      // full-precision r2*FW + c2

  state_e state_q, state_d;

  logic [DIST_WIDTH-1:0] dr_q, dr_d;
  logic [W-1:0]          ow_q, ow_d;
  logic [W-1:0]          fw_q, fw_d;
  logic [W-1:0]          fh_q, fh_d;
  logic [W-1:0]          st_q, st_d;
  logic [W-1:0]          r1_q, r1_d;
  logic [W-1:0]          idx2_q, idx2_d;
  logic                  hit_q, hit_d;
`ifdef DIST_RESOLVER_DIVZERO_EN
  logic                  err_q, err_d;
  logic                  zero_w;
`endif

  logic             div_start;
  logic [CNT_W-1:0] div_nbits;
  logic [DW-1:0]    div_lop, div_dvs;
  logic             div_busy, div_done;
  logic [DW-1:0]    div_quot, div_rem;

  distance_resolver_seq_divider #(
    .W  (DW),
    .CW (CNT_W)
  ) u_div (
    .clk     (clk),
    .reset   (reset),
    .start_i (div_start),
    .nbits_i (div_nbits),
    .lop_i   (div_lop),
    .dvs_i   (div_dvs),
    .busy_o  (div_busy),
    .done_o  (div_done),
    .quot_o  (div_quot),
    .rem_o   (div_rem)
  );

  // Stage datapath. The divider holds its last result, so rem is c1 at the
  // end of DIV_IDX and c2 during CALC; quot is likewise r1 then dv.
  logic [DW-1:0] t_w;
  logic [DW:0]   r2_w;
  logic [PW-1:0] idx2_w;
  logic          hit_w;

  always_comb begin
    t_w    = DW'(dr_q) * DW'(st_q) + div_rem;
    r2_w   = (DW + 1)'(r1_q) + {1'b0, div_quot};
    idx2_w = PW'(r2_w) * PW'(fw_q) + PW'(div_rem);
    hit_w  = (dr_q != '0) && (div_rem < DW'(fw_q)) &&
             (r2_w < (DW + 1)'(fh_q)) && (idx2_w[PW-1:W] == '0);
  end

`ifdef DIST_RESOLVER_DIVZERO_EN
  assign zero_w = (fw_q == '0) || (ow_q == '0) || (st_q == '0);
`endif

  always_comb begin
    state_d   = state_q;
    dr_d      = dr_q;
    ow_d      = ow_q;
    fw_d      = fw_q;
    fh_d      = fh_q;
    st_d      = st_q;
    r1_d      = r1_q;
    idx2_d    = idx2_q;
    hit_d     = hit_q;
`ifdef DIST_RESOLVER_DIVZERO_EN
    err_d     = err_q;
`endif
    div_start = 1'b0;
    // idx1 goes straight into the divider on acceptance, MSB-aligned for an
    // 8-step division; it never needs its own register.
    div_lop   = {idx1, {W{1'b0}}};
    div_dvs   = DW'(fw);
    div_nbits = CNT_W'(DIV_IDX_CYCLES);

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          dr_d      = dr;
          ow_d      = ow;
          fw_d      = fw;
          fh_d      = fh;
          st_d      = st;
          div_start = 1'b1;
          state_d   = ST_DIV_IDX;
        end
      end
      ST_DIV_IDX: begin
        div_lop   = t_w;
        div_dvs   = DW'(ow_q);
        div_nbits = CNT_W'(DIV_T_CYCLES);
        if (div_done && !div_busy) begin
          r1_d      = div_quot[W-1:0];
          div_start = 1'b1;
          state_d   = ST_DIV_T;
        end
      end
      ST_DIV_T: begin
        if (div_done && !div_busy) begin
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
`ifdef DIST_RESOLVER_DIVZERO_EN
        hit_d  = hit_w && !zero_w;
        idx2_d = (hit_w && !zero_w) ? idx2_w[W-1:0] : '0;
        err_d  = zero_w;
`else
        hit_d  = hit_w;
        idx2_d = hit_w ? idx2_w[W-1:0] : '0;
`endif
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dr_q    <= '0;
      ow_q    <= '0;
      fw_q    <= '0;
      fh_q    <= '0;
      st_q    <= '0;
      r1_q    <= '0;
      idx2_q  <= '0;
      hit_q   <= 1'b0;
`ifdef DIST_RESOLVER_DIVZERO_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dr_q    <= dr_d;
      ow_q    <= ow_d;
      fw_q    <= fw_d;
      fh_q    <= fh_d;
      st_q    <= st_d;
      r1_q    <= r1_d;
      idx2_q  <= idx2_d;
      hit_q   <= hit_d;
`ifdef DIST_RESOLVER_DIVZERO_EN
      err_q   <= err_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign idx2      = idx2_q;
  assign hit       = hit_q;
`ifdef DIST_RESOLVER_DIVZERO_EN
  assign err       = err_q;
`endif

endmodule
